// File: rtl/packet_buffer_pkg.sv
// packet_buffer_pkg: shared types, limits and header serialization for the packet buffer
package packet_buffer_pkg;
  localparam int HEADER_WIDTH = 32;
  localparam int HEADER_BYTES = 4;
  localparam logic [15:0] MIN_PACKET_LENGTH = 16'd1;
  localparam logic [15:0] MAX_PACKET_LENGTH = 16'd1500;
  typedef struct packed {
    logic [15:0] length;
    logic [15:0] iface_id;
  } packet_header_t;
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, DRAIN} arb_state_t;
  function automatic logic [7:0] header_byte(input packet_header_t h, input logic [1:0] idx);
    return 8'(32'(h) >> (5'd24 - {idx, 3'b000}));
  endfunction
endpackage

// File: rtl/packet_buffer_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] idx;
  logic found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/packet_buffer_arbiter.sv
// packet_buffer_arbiter: round-robin packet scheduler writing header + length-repaired payload
module packet_buffer_arbiter
  import packet_buffer_pkg::*;
#(
  parameter int NUM_IFACES = 4,
  parameter int IFACE_ID_BASE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IFACES-1:0]   req_valid,
  input  logic [16*NUM_IFACES-1:0] req_length,
  output logic [NUM_IFACES-1:0]   req_ready,
  input  logic [NUM_IFACES-1:0]   in_valid,
  input  logic [8*NUM_IFACES-1:0] in_data,
  input  logic [NUM_IFACES-1:0]   in_last,
  output logic [NUM_IFACES-1:0]   in_ready,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  output logic                    out_sof,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [15:0]             active_id,
  output logic                    err_len_mismatch,
  output logic [15:0]             drop_count
);
  localparam int PW = $clog2(NUM_IFACES);
  arb_state_t state;
  logic [PW-1:0] rr, g, sel;
  logic [NUM_IFACES-1:0] grant;
  packet_header_t hdr;
  logic [15:0] cnt, sel_len;
  logic [1:0] hdr_idx;
  logic len_ok, cur_valid, cur_last;
  rr_arbiter #(.N(NUM_IFACES)) u_rr_arbiter (.req(req_valid), .ptr(rr), .grant(grant));
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_IFACES; i++) if (grant[i]) sel = PW'(i);
  end
  assign sel_len = req_length[{sel, 4'b0000} +: 16];
  assign len_ok = sel_len >= MIN_PACKET_LENGTH && sel_len <= MAX_PACKET_LENGTH;
  assign cur_valid = in_valid[g];
  assign cur_last = in_last[g];
  assign req_ready = state == IDLE ? grant : '0;
  assign in_ready = ((state == PAYLOAD && out_ready) || state == DRAIN) ? NUM_IFACES'(1) << g : '0;
  assign out_valid = state == HDR || state == PAD || (state == PAYLOAD && cur_valid);
  assign out_data = state == HDR ? header_byte(hdr, hdr_idx) : state == PAYLOAD ? in_data[{g, 3'b000} +: 8] : 8'h00;
  assign out_sof = state == HDR && hdr_idx == 2'd0;
  assign out_last = (state == PAYLOAD || state == PAD) && cnt == 16'd1;
  assign active_id = state == IDLE ? 16'h0000 : hdr.iface_id;
  // cnt holds the bytes still owed downstream; it is >=1 whenever PAYLOAD/PAD is active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr <= PW'(NUM_IFACES - 1);
      g <= '0;
      hdr <= '0;
      cnt <= '0;
      hdr_idx <= '0;
      err_len_mismatch <= 1'b0;
      drop_count <= '0;
    end else begin
      err_len_mismatch <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          rr <= sel;
          if (len_ok) begin
            g <= sel;
            hdr <= '{length: sel_len, iface_id: 16'(IFACE_ID_BASE) + 16'(sel)};
            hdr_idx <= '0;
            state <= HDR;
          end else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
        HDR: if (out_ready) begin
          hdr_idx <= hdr_idx + 2'd1;
          if (hdr_idx == 2'(HEADER_BYTES - 1)) begin
            cnt <= hdr.length;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: if (cur_valid && out_ready) begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            err_len_mismatch <= !cur_last;
            state <= cur_last ? IDLE : DRAIN;
          end else if (cur_last) begin
            err_len_mismatch <= 1'b1;
            state <= PAD;
          end
        end
        PAD: if (out_ready) begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) state <= IDLE;
        end
        DRAIN: if (cur_valid && cur_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_packet_buffer_arbiter.sv
// tb_packet_buffer_arbiter: table-driven packets with a byte scoreboard plus grant-order and reset sequences
module tb_packet_buffer_arbiter;
  localparam int N = 4;
  localparam int BASE = 16'h10;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, in_valid = '0, in_last = '0, in_ready;
  logic [16*N-1:0] req_length = '0;
  logic [8*N-1:0] in_data = '0;
  logic out_valid, out_sof, out_last, out_ready = 1'b1, err_len_mismatch;
  logic [7:0] out_data;
  logic [15:0] active_id, drop_count;
  always #5 clk = ~clk;
  packet_buffer_arbiter #(.NUM_IFACES(N), .IFACE_ID_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_length(req_length), .req_ready(req_ready),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_last(out_last), .out_ready(out_ready),
    .active_id(active_id), .err_len_mismatch(err_len_mismatch), .drop_count(drop_count)
  );
  typedef struct {logic [7:0] data; logic sof; logic last; logic [15:0] id;} exp_t;
  typedef struct {int iface; int len; int nsend; logic [7:0] seed; bit ok; int exp_err; int exp_drops;} vec_t;
  exp_t sb[$];
  int grants[$];
  int checks = 0, errors = 0, err_pulses = 0, rr_pulses = 0;
  bit bp_en = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1 out_ready = bp_en ? ~out_ready : 1'b1;
  end
  logic stall = 1'b0, p_sof, p_last;
  logic [7:0] p_data;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (err_len_mismatch) err_pulses++;
      for (int i = 0; i < N; i++) if (req_ready[i]) begin
        rr_pulses++;
        grants.push_back(i);
      end
      if (stall) chk("hold", {out_valid, out_sof, out_last, out_data}, {1'b1, p_sof, p_last, p_data});
      stall = out_valid && !out_ready;
      p_data = out_data;
      p_sof = out_sof;
      p_last = out_last;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_byte", {out_data, out_sof, out_last}, 32'hFFFFFFFF);
        else begin
          e = sb.pop_front();
          chk("out_byte", {active_id, out_data, out_sof, out_last}, {e.id, e.data, e.sof, e.last});
        end
      end
    end else stall = 1'b0;
  end
  task automatic wait_rdy(input int i, input bit for_req, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (for_req ? req_ready[i] : in_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout iface %0d got no ready expected ready within 400 cycles", i);
    end
  endtask
  task automatic send_pkt(input int i, input int len, input int nsend, input logic [7:0] seed, input bit ok_len);
    bit ok;
    @(posedge clk);
    #1 req_valid[i] = 1'b1;
    req_length[16*i +: 16] = 16'(len);
    wait_rdy(i, 1'b1, ok);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    if (ok && ok_len) for (int k = 0; k < nsend; k++) begin
      in_valid[i] = 1'b1;
      in_data[8*i +: 8] = seed + 8'(k * 17);
      in_last[i] = k == nsend - 1;
      wait_rdy(i, 1'b0, ok);
      if (!ok) break;
      @(posedge clk);
      #1;
    end
    in_valid[i] = 1'b0;
    in_last[i] = 1'b0;
  endtask
  task automatic push_exp(input int i, input int len, input int nsend, input logic [7:0] seed);
    logic [15:0] l, id;
    l = 16'(len);
    id = 16'(BASE + i);
    sb.push_back('{l[15:8], 1'b1, 1'b0, id});
    sb.push_back('{l[7:0], 1'b0, 1'b0, id});
    sb.push_back('{id[15:8], 1'b0, 1'b0, id});
    sb.push_back('{id[7:0], 1'b0, 1'b0, id});
    for (int k = 0; k < len; k++) sb.push_back('{k < nsend ? seed + 8'(k * 17) : 8'h00, 1'b0, k == len - 1, id});
  endtask
  task automatic wait_empty();
    for (int c = 0; c < 5000 && sb.size() != 0; c++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask
  vec_t vt[7];
  int eg[3];
  int e0, r0;
  initial begin
    vt[0] = '{0, 4, 4, 8'hAA, 1'b1, 0, 0};
    vt[1] = '{1, 0, 0, 8'h00, 1'b0, 0, 1};
    vt[2] = '{1, 1501, 0, 8'h00, 1'b0, 0, 2};
    vt[3] = '{1, 1500, 1500, 8'h01, 1'b1, 0, 2};
    vt[4] = '{3, 6, 3, 8'h31, 1'b1, 1, 2};
    vt[5] = '{2, 2, 4, 8'h21, 1'b1, 1, 2};
    vt[6] = '{3, 1, 1, 8'h71, 1'b1, 0, 2};
    eg = '{0, 2, 0};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {out_valid, out_sof, out_last, err_len_mismatch, out_data}, 0);
    chk("rst_ids", {active_id, drop_count}, 0);
    chk("rst_readies", {req_ready, in_ready}, 0);
    for (int v = 0; v < 7; v++) begin
      bp_en = v >= 3;
      e0 = err_pulses;
      r0 = rr_pulses;
      if (vt[v].ok) push_exp(vt[v].iface, vt[v].len, vt[v].nsend, vt[v].seed);
      send_pkt(vt[v].iface, vt[v].len, vt[v].nsend, vt[v].seed, vt[v].ok);
      wait_empty();
      chk($sformatf("vec%0d_err_pulses", v), err_pulses - e0, vt[v].exp_err);
      chk($sformatf("vec%0d_drop_count", v), drop_count, vt[v].exp_drops);
      chk($sformatf("vec%0d_req_ready_pulses", v), rr_pulses - r0, 1);
    end
    grants.delete();
    push_exp(0, 2, 2, 8'h01);
    push_exp(2, 2, 2, 8'h21);
    push_exp(0, 2, 2, 8'h41);
    fork
      begin
        send_pkt(0, 2, 2, 8'h01, 1'b1);
        send_pkt(0, 2, 2, 8'h41, 1'b1);
      end
      send_pkt(2, 2, 2, 8'h21, 1'b1);
    join
    wait_empty();
    for (int k = 0; k < 3; k++) chk($sformatf("grant_order%0d", k), k < grants.size() ? grants[k] : -1, eg[k]);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    push_exp(1, 8, 2, 8'h90);
    void'(sb.pop_back());
    repeat (5) void'(sb.pop_back());
    @(posedge clk);
    #1 req_valid[1] = 1'b1;
    req_length[31:16] = 16'd8;
    begin
      bit ok;
      wait_rdy(1, 1'b1, ok);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        in_valid[1] = 1'b1;
        in_data[15:8] = 8'h90 + 8'(k * 17);
        wait_rdy(1, 1'b0, ok);
        @(posedge clk);
        #1;
      end
    end
    in_data[15:8] = 8'hEE;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midpkt_rst_outputs", {out_valid, out_sof, out_last, err_len_mismatch}, 0);
    chk("midpkt_rst_ids", {active_id, drop_count}, 0);
    chk("midpkt_rst_readies", {req_ready, in_ready}, 0);
    chk("midpkt_sb_consumed", sb.size(), 0);
    in_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(1, 1, 1, 8'h5A);
    send_pkt(1, 1, 1, 8'h5A, 1'b1);
    wait_empty();
    chk("post_rst_grant", grants.size() > 0 ? grants[grants.size()-1] : -1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got no finish expected finish before 1000000ns");
    $fatal(1);
  end
endmodule
